// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern generator.
//   mode_e : pattern selection encodings carried on the 2-bit mode port
//   dir_e  : bounce direction
//   CNT_W  : width of the tick counter and of the period value
package led_pattern_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        MODE_BOUNCE  = 2'd0,
        MODE_CHASE_L = 2'd1,
        MODE_CHASE_R = 2'd2,
        MODE_BLINK   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/led_tick_gen.sv
// Tick counter that paces pattern steps.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the count
//   en     : count enable; count holds while low
//   clr    : synchronous clear (pattern restart / recovery)
//   period : cycles per step; 0 is treated as 1
//   adv    : high in the cycle whose edge completes a step (combinational)
module led_tick_gen
    import led_pattern_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] period,
    output logic             adv
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] period_m1;

    // A zero period would underflow; run it as a period of one.
    assign period_m1 = (period == '0) ? '0 : period - 1'b1;

    // >= rather than == so that shrinking the period mid-count still wraps.
    assign adv = en && (cnt_q >= period_m1);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = adv ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: bounce, chase-left, chase-right and blink patterns,
// stepping once every period of enabled clock cycles.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   en     : pattern advance enable
//   mode   : 0 bounce, 1 chase-left, 2 chase-right, 3 blink
//   period : (only with LED_PATTERN_RUNTIME_PERIOD_EN) runtime step period,
//            replacing TICKS_PER_STATE; 0 behaves as 1
//   y      : LED drive
//   step   : one-cycle pulse in the first cycle a newly advanced y appears
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int unsigned N_LEDS          = 3,
    parameter int unsigned TICKS_PER_STATE = 32'd40_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        mode,
`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
    input  logic [CNT_W-1:0]  period,
`endif
    output logic [N_LEDS-1:0] y,
    output logic              step
);

    localparam logic [N_LEDS-1:0] YOne = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] YTwo = YOne << 1;
    localparam logic [N_LEDS-1:0] YTop = YOne << (N_LEDS - 2);

    function automatic logic [N_LEDS-1:0] init_y(input logic [1:0] m);
        return (m == MODE_BLINK) ? '1 : YOne;
    endfunction

    function automatic logic is_onehot(input logic [N_LEDS-1:0] v);
        return (v != '0) && ((v & (v - YOne)) == '0);
    endfunction

    logic [1:0]        mode_q;
    dir_e              dir_q;
    dir_e              dir_d;
    logic [N_LEDS-1:0] y_d;
    logic              step_d;
    logic              restart;
    logic              recover;
    logic              adv;
    logic [CNT_W-1:0]  period_sel;

`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
    assign period_sel = period;
`else
    assign period_sel = CNT_W'(TICKS_PER_STATE);
`endif

    assign restart = (mode != mode_q);
    // Blink legitimately shows all-ones/all-zeros, so it is exempt.
    assign recover = (mode_q != MODE_BLINK) && !is_onehot(y);

    led_tick_gen u_tick (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .clr    (restart | recover),
        .period (period_sel),
        .adv    (adv)
    );

    always_comb begin
        y_d    = y;
        dir_d  = dir_q;
        step_d = 1'b0;
        if (restart) begin
            y_d   = init_y(mode);
            dir_d = DIR_LEFT;
        end else if (recover) begin
            y_d   = YOne;
            dir_d = DIR_LEFT;
        end else if (adv) begin
            step_d = 1'b1;
            unique case (mode_q)
                MODE_BOUNCE: begin
                    // Direction flips on the step that reaches an end LED.
                    if (dir_q == DIR_LEFT) begin
                        y_d = y << 1;
                        if (y == YTop) dir_d = DIR_RIGHT;
                    end else begin
                        y_d = y >> 1;
                        if (y == YTwo) dir_d = DIR_LEFT;
                    end
                end
                MODE_CHASE_L: y_d = {y[N_LEDS-2:0], y[N_LEDS-1]};
                MODE_CHASE_R: y_d = {y[0], y[N_LEDS-1:1]};
                MODE_BLINK:   y_d = ~y;
                default:      y_d = y;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= init_y(mode);
            dir_q  <= DIR_LEFT;
            step   <= 1'b0;
            mode_q <= mode;
        end else begin
            y      <= y_d;
            dir_q  <= dir_d;
            step   <= step_d;
            mode_q <= mode;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed scenarios followed by
// randomized stimulus, all compared against a behavioural reference model.
module tb_led_pattern_gen;

    localparam int unsigned N = 4;
    localparam int unsigned T = 4;
    localparam logic [N-1:0] MASK = '1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [N-1:0] y;
    logic         step;
`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
    logic [31:0]  period;
`endif

    always #5 clk = ~clk;

    led_pattern_gen #(
        .N_LEDS          (N),
        .TICKS_PER_STATE (T)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .mode   (mode),
`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
        .period (period),
`endif
        .y      (y),
        .step   (step)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: LED position / travel direction for bounce, plain
    // rotations and inversion for the others, integer tick count.
    logic [N-1:0] m_y;
    logic         m_step;
    longint       m_cnt;
    int           m_p;
    bit           m_up;
    logic [1:0]   m_mode_q;

    function automatic longint eff_period();
`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
        return (period == 0) ? 1 : longint'(period);
`else
        return T;
`endif
    endfunction

    task automatic model_load(input logic [N-1:0] v);
        m_y = v; m_cnt = 0; m_p = 0; m_up = 1; m_step = 0;
    endtask

    task automatic model_update();
        if (rst || mode != m_mode_q) begin
            model_load((mode == 2'd3) ? MASK : N'(1));
            m_mode_q = mode;
        end else if (m_mode_q != 2'd3 && $countones(m_y) != 1) begin
            model_load(N'(1));
        end else if (en) begin
            if (m_cnt >= eff_period() - 1) begin
                m_cnt  = 0;
                m_step = 1;
                case (m_mode_q)
                    2'd0: begin
                        if (m_up) begin
                            m_p++;
                            if (m_p == N - 1) m_up = 0;
                        end else begin
                            m_p--;
                            if (m_p == 0) m_up = 1;
                        end
                        m_y = N'(1 << m_p);
                    end
                    2'd1: m_y = (m_y << 1) | (m_y >> (N - 1));
                    2'd2: m_y = (m_y >> 1) | (m_y << (N - 1));
                    default: m_y = ~m_y;
                endcase
            end else begin
                m_cnt++;
                m_step = 0;
            end
        end else begin
            m_step = 0;
        end
    endtask

    task automatic cycle();
        model_update();
        @(posedge clk);
        #1;
        check_val("y", 32'(y), 32'(m_y));
        check_val("step", 32'(step), 32'(m_step));
    endtask

    logic [N-1:0] seqv [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                               4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [N-1:0] held;
    bit           found;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0;
        m_mode_q = 2'd0;
        model_load(N'(1));
`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
        period = T;
`endif
        #1;
        cycle();
        check_val("reset_y", 32'(y), 32'h1);
        check_val("reset_step", 32'(step), 32'h0);
        rst = 1'b0; en = 1'b1;

        // Bounce sequence, each value held T cycles.
        for (int k = 1; k < 28; k++) begin
            cycle();
            check_val("bounce_seq", 32'(y), 32'(seqv[k / 4]));
            check_val("bounce_step", 32'(step), 32'((k % 4) == 0));
        end

        // Freeze mid-count.
        cycle();
        held = y;
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            check_val("freeze_y", 32'(y), 32'(held));
            check_val("freeze_step", 32'(step), 32'h0);
        end
        en = 1'b1;
        for (int k = 0; k < 8; k++) cycle();

        // Reset pulse while y=0100.
        found = 0;
        for (int k = 0; k < 60 && !found; k++) begin
            cycle();
            if (y == 4'b0100) found = 1;
        end
        check_val("reach_0100", 32'(found), 32'h1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_val("midrst_y", 32'(y), 32'h1);
        for (int k = 1; k <= T; k++) begin
            cycle();
            check_val("midrst_step", 32'(step), 32'(k == T));
        end
        check_val("midrst_adv_y", 32'(y), 32'h2);

        // Recovery from non-one-hot values.
        force dut.y = 4'b0110;
        release dut.y;
        m_y = 4'b0110;
        cycle();
        check_val("recov_bounce", 32'(y), 32'h1);
        mode = 2'd1;
        for (int k = 0; k < 6; k++) cycle();
        force dut.y = 4'b0000;
        release dut.y;
        m_y = 4'b0000;
        cycle();
        check_val("recov_chase", 32'(y), 32'h1);
        for (int k = 0; k < 12; k++) cycle();

        // Chase-right then blink.
        mode = 2'd2;
        cycle();
        check_val("chase_r_init", 32'(y), 32'h1);
        for (int k = 0; k < 12; k++) cycle();
        mode = 2'd3;
        cycle();
        check_val("blink_init", 32'(y), 32'hf);
        for (int k = 0; k < 12; k++) cycle();

`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
        period = 0;
        mode = 2'd1;
        cycle();
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_val("period0_step", 32'(step), 32'h1);
        end
        period = T;
`endif

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(99) == 0);
            en  = ($urandom_range(9) != 0);
            if ($urandom_range(39) == 0) mode = 2'($urandom);
`ifdef LED_PATTERN_RUNTIME_PERIOD_EN
            if ($urandom_range(99) == 0) period = $urandom_range(6);
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
